and_result_checker: RTL and testbench
=====================================

# and_result_checker

Sequential checker that sits directly downstream of the two-input AND gate and consumes its output `c` together with the operands `a`, `b` that produced it. It accepts a run of valid-qualified samples, classifies each `c` as 0, 1 or unknown (X/Z) using 4-state comparison, compares known results against `a & b`, and accumulates counters plus a pass/fail verdict. It gives gate-level benches and bring-up a self-checking stage in place of eyeballing `$monitor` traces.

## Interface
- `N_SAMPLES`, default 4: samples accepted per run; 4 covers the full truth table. Legal range is 1 to 2**CNT_W−1.
- `CNT_W`, default 8: width of every counter and of the index output.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `start` input 1: begin a run; honoured only in IDLE or DONE.
- `in_valid` input 1: `a`/`b`/`c` hold a sample this cycle.
- `a`, `b` input 1 each: gate operands, 4-state.
- `c` input 1: gate output, 4-state.
- `busy` output 1: high in RUN.
- `done` output 1: high in DONE.
- `pass` output 1: meaningful only when `done` is high; 1 when `mismatch_cnt == 0`.
- `ones_cnt`, `zeros_cnt`, `unk_cnt`, `mismatch_cnt` output CNT_W each: per-run counters.
- `first_err_idx` output CNT_W: sample index (0-based) of the first mismatch; all-ones when there is none.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN when `start` is high. All counters clear and `first_err_idx` is set to all-ones on the same edge.
  - RUN accepts a sample on every edge where `in_valid === 1`. `in_valid` at X/Z or 0 means no sample.
  - RUN → DONE on the edge that accepts sample number N_SAMPLES.
  - DONE holds all results. `start` → RUN with a clear, identical to the IDLE transition.
  - `start` is ignored in RUN.
- Per accepted sample, classification is decided in priority order:
  1. `a` or `b` unknown: increment `unk_cnt`. No comparison is made; the sample does not count as a mismatch.
  2. `c` unknown (X or Z): increment `unk_cnt` and `mismatch_cnt`.
  3. Otherwise: increment `ones_cnt` or `zeros_cnt` according to `c`. If `c !== (a & b)`, increment `mismatch_cnt`.
- On the first mismatch of a run, latch the internal sample index into `first_err_idx`.
- Counters saturate at all-ones and never wrap.
- The sample index counts accepted samples, including those in category 1.
- Every output is driven to a known 0/1 value at all times; no X propagates to outputs.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `pass`=0, all counters 0, `first_err_idx` all-ones.
- `rst` has priority over every other input. Asserting it mid-run returns the block to IDLE on that edge and discards partial results.
- All outputs are registered. The effect of a sample accepted at edge k is visible after edge k.
- `done` and `pass` rise after the edge that accepts the final sample, with zero extra latency. They hold until `start` or `rst`.
- `start` and `in_valid` high on the same edge in IDLE or DONE: the edge performs the clear and enters RUN; the sample is not accepted.
- `in_valid` in IDLE or DONE is ignored.
- When N_SAMPLES=1, the block goes RUN → DONE on the first accepted sample.

## Structure
- Shared package `and_chk_pkg`:
  - state enum `chk_state_t` {IDLE, RUN, DONE}
  - sample class enum {CLS_ZERO, CLS_ONE, CLS_UNK_IN, CLS_UNK_OUT}
  - `IDX_NONE` constant (all-ones)
- One sub-module, `and_sample_classify`: purely combinational. Takes `a`, `b`, `c`; produces the class code and a mismatch bit. It is the only place 4-state comparisons appear.
- The top level holds the FSM, counters and saturation logic.

## Test plan
- Full truth table: `start`, then samples (0,0,0), (0,1,0), (1,0,0), (1,1,1) with `in_valid` high → `done`=1, `pass`=1, `zeros_cnt`=3, `ones_cnt`=1, `unk_cnt`=0, `mismatch_cnt`=0, `first_err_idx`=255.
- Faulty gate: same run but the third sample is (1,0,1) → `pass`=0, `mismatch_cnt`=1, `first_err_idx`=2, `ones_cnt`=2.
- Unknowns: samples (x,x,x), (0,0,z), (1,1,1), (0,1,0) → `unk_cnt`=2, `mismatch_cnt`=1, `first_err_idx`=1, `pass`=0.
- Gaps, collision and ignored `start`:
  - `in_valid` low for 3 cycles between samples → `done` rises only after the 4th accepted sample.
  - `start` pulsed in RUN → no effect.
  - `start`+`in_valid` in DONE → counters clear and that sample is not counted.
- Reset mid-run: `rst` high after 2 accepted samples → next cycle `busy`=0, all counters 0, `first_err_idx`=255. A fresh run then completes normally.
- Saturation: CNT_W=2, N_SAMPLES=3, all samples (1,1,0) → `mismatch_cnt`=3 with no wrap, `first_err_idx`=0.

Source files
------------

// File: rtl/and_chk_pkg.sv
// Shared types and constants for the AND-gate result checker.
package and_chk_pkg;

  // Checker run state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_t;

  // Classification of one accepted (a, b, c) sample.
  typedef enum logic [1:0] {
    CLS_ZERO    = 2'd0,
    CLS_ONE     = 2'd1,
    CLS_UNK_IN  = 2'd2,
    CLS_UNK_OUT = 2'd3
  } sample_cls_t;

  // "No mismatch seen" marker for first_err_idx; truncated to CNT_W by users.
  localparam logic [31:0] IDX_NONE = '1;

endpackage

// File: rtl/and_sample_classify.sv
// Combinational classifier for one gate sample. All 4-state (X/Z) handling
// for the checker lives here so the sequential logic only sees clean codes.
module and_sample_classify
  import and_chk_pkg::*;
(
  input  logic        a_i,
  input  logic        b_i,
  input  logic        c_i,
  output sample_cls_t cls_o,
  output logic        mismatch_o
);

  logic a_unk;
  logic b_unk;
  logic c_unk;

  assign a_unk = (a_i !== 1'b0) && (a_i !== 1'b1);
  assign b_unk = (b_i !== 1'b0) && (b_i !== 1'b1);
  assign c_unk = (c_i !== 1'b0) && (c_i !== 1'b1);

  // Unknown operands make the sample uncheckable; an unknown output from
  // known operands is a real gate fault.
  always_comb begin
    cls_o      = CLS_ZERO;
    mismatch_o = 1'b0;
    if (a_unk || b_unk) begin
      cls_o      = CLS_UNK_IN;
      mismatch_o = 1'b0;
    end else if (c_unk) begin
      cls_o      = CLS_UNK_OUT;
      mismatch_o = 1'b1;
    end else begin
      cls_o      = (c_i === 1'b1) ? CLS_ONE : CLS_ZERO;
      mismatch_o = (c_i !== (a_i & b_i));
    end
  end

endmodule

// File: rtl/and_result_checker.sv
// Sequential checker downstream of a two-input AND gate: accepts N_SAMPLES
// valid samples per run, counts result classes and mismatches, and reports
// a pass/fail verdict together with the index of the first mismatch.
module and_result_checker
  import and_chk_pkg::*;
#(
  parameter int unsigned N_SAMPLES = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] ones_cnt,
  output logic [CNT_W-1:0] zeros_cnt,
  output logic [CNT_W-1:0] unk_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] first_err_idx
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);
  localparam logic [CNT_W-1:0] NONE_IDX = CNT_W'(IDX_NONE);

  chk_state_t       state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] ones_q, ones_d;
  logic [CNT_W-1:0] zeros_q, zeros_d;
  logic [CNT_W-1:0] unk_q, unk_d;
  logic [CNT_W-1:0] mis_q, mis_d;
  logic [CNT_W-1:0] fei_q, fei_d;
  logic [CNT_W-1:0] idx_q, idx_d;

  sample_cls_t      cls;
  logic             mismatch;

  and_sample_classify u_classify (
    .a_i        (a),
    .b_i        (b),
    .c_i        (c),
    .cls_o      (cls),
    .mismatch_o (mismatch)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Next-state: run control, per-sample counting and the end-of-run verdict.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    ones_d  = ones_q;
    zeros_d = zeros_q;
    unk_d   = unk_q;
    mis_d   = mis_q;
    fei_d   = fei_q;
    idx_d   = idx_q;

    unique case (state_q)
      IDLE, DONE: begin
        // A sample presented together with start is dropped by design.
        if (start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          ones_d  = '0;
          zeros_d = '0;
          unk_d   = '0;
          mis_d   = '0;
          fei_d   = NONE_IDX;
          idx_d   = '0;
        end
      end
      RUN: begin
        if (in_valid) begin
          unique case (cls)
            CLS_ZERO:                zeros_d = sat_inc(zeros_q);
            CLS_ONE:                 ones_d  = sat_inc(ones_q);
            CLS_UNK_IN, CLS_UNK_OUT: unk_d   = sat_inc(unk_q);
          endcase
          if (mismatch) begin
            mis_d = sat_inc(mis_q);
            // Saturation never returns the count to zero, so this fires once.
            if (mis_q == '0) begin
              fei_d = idx_q;
            end
          end
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (mis_d == '0);
          end else begin
            idx_d = idx_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        pass_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      ones_q  <= '0;
      zeros_q <= '0;
      unk_q   <= '0;
      mis_q   <= '0;
      fei_q   <= NONE_IDX;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      ones_q  <= ones_d;
      zeros_q <= zeros_d;
      unk_q   <= unk_d;
      mis_q   <= mis_d;
      fei_q   <= fei_d;
      idx_q   <= idx_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign ones_cnt      = ones_q;
  assign zeros_cnt     = zeros_q;
  assign unk_cnt       = unk_q;
  assign mismatch_cnt  = mis_q;
  assign first_err_idx = fei_q;

endmodule

// File: tb/tb_and_result_checker.sv
// Directed self-checking bench for and_result_checker. A second instance
// with CNT_W=2, N_SAMPLES=3 shares the stimulus for the saturation case.
module tb_and_result_checker;

  logic clk = 1'b0;
  logic rst, start, in_valid, a, b, c;

  logic       busy, done, pass;
  logic [7:0] ones_cnt, zeros_cnt, unk_cnt, mismatch_cnt, first_err_idx;

  logic       s_busy, s_done, s_pass;
  logic [1:0] s_ones, s_zeros, s_unk, s_mis, s_fei;

  int checks = 0;
  int errors = 0;

  logic [42:0] exp_v;
  logic [12:0] exp_s;

  always #5 clk = ~clk;

  and_result_checker #(.N_SAMPLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .a(a), .b(b), .c(c),
    .busy(busy), .done(done), .pass(pass),
    .ones_cnt(ones_cnt), .zeros_cnt(zeros_cnt), .unk_cnt(unk_cnt),
    .mismatch_cnt(mismatch_cnt), .first_err_idx(first_err_idx)
  );

  and_result_checker #(.N_SAMPLES(3), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .a(a), .b(b), .c(c),
    .busy(s_busy), .done(s_done), .pass(s_pass),
    .ones_cnt(s_ones), .zeros_cnt(s_zeros), .unk_cnt(s_unk),
    .mismatch_cnt(s_mis), .first_err_idx(s_fei)
  );

  // {busy, done, pass, ones, zeros, unk, mismatch, first_err_idx}
  function automatic logic [42:0] snap();
    return {busy, done, pass, ones_cnt, zeros_cnt, unk_cnt, mismatch_cnt, first_err_idx};
  endfunction

  function automatic logic [12:0] snap_s();
    return {s_busy, s_done, s_pass, s_ones, s_zeros, s_unk, s_mis, s_fei};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic sa, input logic sb, input logic sc);
    a = sa; b = sb; c = sc; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    exp_v = {1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'hFF};
    checks++;
    if (snap() !== exp_v) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", snap(), exp_v);
    end
    // in_valid while idle must not count anything
    send(1'b1, 1'b1, 1'b0);
    send(1'b0, 1'b0, 1'b0);
    checks++;
    if (snap() !== exp_v) begin
      errors++;
      $display("FAIL idle_valid_ignored: got %h expected %h", snap(), exp_v);
    end
  endtask

  task automatic test_truth_table();
    do_reset();
    pulse_start();
    exp_v = {1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'hFF};
    checks++;
    if (snap() !== exp_v) begin
      errors++;
      $display("FAIL tt_after_start: got %h expected %h", snap(), exp_v);
    end
    send(1'b0, 1'b0, 1'b0);
    send(1'b0, 1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    exp_v = {1'b1, 1'b0, 1'b0, 8'd0, 8'd3, 8'd0, 8'd0, 8'hFF};
    checks++;
    if (snap() !== exp_v) begin
      errors++;
      $display("FAIL tt_after_3: got %h expected %h", snap(), exp_v);
    end
    send(1'b1, 1'b1, 1'b1);
    exp_v = {1'b0, 1'b1, 1'b1, 8'd1, 8'd3, 8'd0, 8'd0, 8'hFF};
    checks++;
    if (snap() !== exp_v) begin
      errors++;
      $display("FAIL tt_done: got %h expected %h", snap(), exp_v);
    end
    // results hold in DONE
    step(); step();
    checks++;
    if (snap() !== exp_v) begin
      errors++;
      $display("FAIL tt_hold: got %h expected %h", snap(), exp_v);
    end
  endtask

  task automatic test_faulty_gate();
    do_reset();
    pulse_start();
    send(1'b0, 1'b0, 1'b0);
    send(1'b0, 1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b1);
    send(1'b1, 1'b1, 1'b1);
    exp_v = {1'b0, 1'b1, 1'b0, 8'd2, 8'd2, 8'd0, 8'd1, 8'd2};
    checks++;
    if (snap() !== exp_v) begin
      errors++;
      $display("FAIL faulty_gate: got %h expected %h", snap(), exp_v);
    end
  endtask

  task automatic test_unknowns();
    logic [2:0] vec [4];
    logic       probe;
    logic       sa, sb, sc;
    logic [7:0] e_ones, e_zeros, e_unk, e_mis, e_fei;
    vec[0] = 3'bxxx;
    vec[1] = 3'b00z;
    vec[2] = 3'b111;
    vec[3] = 3'b010;
    probe  = 1'bx;
    if ($isunknown(probe)) begin
      // 4-state simulator: hand-computed values
      e_ones = 8'd1; e_zeros = 8'd1; e_unk = 8'd2; e_mis = 8'd1; e_fei = 8'd1;
    end else begin
      // 2-state simulator: X/Z collapse to known levels; evaluate what is driven
      e_ones = 0; e_zeros = 0; e_unk = 0; e_mis = 0; e_fei = 8'hFF;
      for (int i = 0; i < 4; i++) begin
        sa = vec[i][2]; sb = vec[i][1]; sc = vec[i][0];
        if ($isunknown(sa) || $isunknown(sb)) begin
          e_unk++;
        end else if ($isunknown(sc)) begin
          e_unk++;
          if (e_mis == 0) e_fei = 8'(i);
          e_mis++;
        end else begin
          if (sc) e_ones++; else e_zeros++;
          if (sc !== (sa & sb)) begin
            if (e_mis == 0) e_fei = 8'(i);
            e_mis++;
          end
        end
      end
    end
    do_reset();
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      send(vec[i][2], vec[i][1], vec[i][0]);
    end
    exp_v = {1'b0, 1'b1, (e_mis == 0), e_ones, e_zeros, e_unk, e_mis, e_fei};
    checks++;
    if (snap() !== exp_v) begin
      errors++;
      $display("FAIL unknowns: got %h expected %h", snap(), exp_v);
    end
  endtask

  task automatic test_gaps_and_start();
    do_reset();
    pulse_start();
    send(1'b0, 1'b0, 1'b0);
    step();
    pulse_start();           // ignored in RUN
    step();
    exp_v = {1'b1, 1'b0, 1'b0, 8'd0, 8'd1, 8'd0, 8'd0, 8'hFF};
    checks++;
    if (snap() !== exp_v) begin
      errors++;
      $display("FAIL start_in_run: got %h expected %h", snap(), exp_v);
    end
    send(1'b0, 1'b1, 1'b0);
    step(); step(); step();
    send(1'b1, 1'b0, 1'b0);
    step(); step(); step();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL gap_done_early: got %b expected 0", done);
    end
    send(1'b1, 1'b1, 1'b1);
    exp_v = {1'b0, 1'b1, 1'b1, 8'd1, 8'd3, 8'd0, 8'd0, 8'hFF};
    checks++;
    if (snap() !== exp_v) begin
      errors++;
      $display("FAIL gap_done: got %h expected %h", snap(), exp_v);
    end
    // start + in_valid in DONE: clear, sample dropped
    start = 1'b1;
    send(1'b1, 1'b1, 1'b0);
    start = 1'b0;
    exp_v = {1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'hFF};
    checks++;
    if (snap() !== exp_v) begin
      errors++;
      $display("FAIL collision_clear: got %h expected %h", snap(), exp_v);
    end
    send(1'b1, 1'b1, 1'b0);
    exp_v = {1'b1, 1'b0, 1'b0, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0};
    checks++;
    if (snap() !== exp_v) begin
      errors++;
      $display("FAIL after_collision: got %h expected %h", snap(), exp_v);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    pulse_start();
    send(1'b1, 1'b1, 1'b0);
    send(1'b1, 1'b1, 1'b1);
    exp_v = {1'b1, 1'b0, 1'b0, 8'd1, 8'd1, 8'd0, 8'd1, 8'd0};
    checks++;
    if (snap() !== exp_v) begin
      errors++;
      $display("FAIL pre_reset: got %h expected %h", snap(), exp_v);
    end
    rst = 1'b1; start = 1'b1; in_valid = 1'b1; a = 1'b1; b = 1'b1; c = 1'b0;
    step();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    exp_v = {1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'hFF};
    checks++;
    if (snap() !== exp_v) begin
      errors++;
      $display("FAIL mid_run_reset: got %h expected %h", snap(), exp_v);
    end
    pulse_start();
    send(1'b0, 1'b0, 1'b0);
    send(1'b0, 1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b1, 1'b1);
    exp_v = {1'b0, 1'b1, 1'b1, 8'd1, 8'd3, 8'd0, 8'd0, 8'hFF};
    checks++;
    if (snap() !== exp_v) begin
      errors++;
      $display("FAIL fresh_run: got %h expected %h", snap(), exp_v);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    pulse_start();
    send(1'b1, 1'b1, 1'b0);
    send(1'b1, 1'b1, 1'b0);
    checks++;
    if (s_done !== 1'b0) begin
      errors++;
      $display("FAIL sat_done_early: got %b expected 0", s_done);
    end
    send(1'b1, 1'b1, 1'b0);
    exp_s = {1'b0, 1'b1, 1'b0, 2'd0, 2'd3, 2'd0, 2'd3, 2'd0};
    checks++;
    if (snap_s() !== exp_s) begin
      errors++;
      $display("FAIL saturation: got %h expected %h", snap_s(), exp_s);
    end
    exp_v = {1'b1, 1'b0, 1'b0, 8'd0, 8'd3, 8'd0, 8'd3, 8'd0};
    checks++;
    if (snap() !== exp_v) begin
      errors++;
      $display("FAIL main_three_mismatch: got %h expected %h", snap(), exp_v);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0;
    test_reset();
    test_truth_table();
    test_faulty_gate();
    test_unknowns();
    test_gaps_and_start();
    test_reset_mid_run();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
